pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
//  Generalises the fixed EX/MEM-style latch: arbitrary data and control widths, and backpressure without data loss.
//  Per-stage flush inserts a bubble, and a saturating counter records stall cycles.
//  Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  DATA_W   16  width of datapath payload (ALU result, B operand, PCs, ...)
//  CTRL_W   12  width of control payload (RegWrite, DMemEn, WriteRegister, ...); zeroed on bubble
//  CNT_W    16  width of stall counter stall_cnt
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       sync clear of both entries (bubble insertion)
//  in_valid   in   1       upstream presents data_in/ctrl_in
//  in_ready   out  1       stage can accept; registered
//  data_in    in   DATA_W  upstream datapath payload
//  ctrl_in    in   CTRL_W  upstream control payload
//  out_valid  out  1       data_out/ctrl_out hold a valid entry; registered
//  out_ready  in   1       downstream accepts
//  data_out   out  DATA_W  head-entry datapath payload
//  ctrl_out   out  CTRL_W  head-entry control payload; all-zero whenever out_valid=0
//  stall_cnt  out  CNT_W   count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Handshakes:
//  - Accept (A) = in_valid & in_ready. Issue (I) = out_valid & out_ready.
//  - Upstream must hold data while in_valid=1 and in_ready=0.
//  Storage:
//  - Two entries: main (drives outputs) and skid. No combinational path from inputs to outputs.
//  FSM (state reg, one-hot or binary):
//   EMPTY: out_valid=0, in_ready=1.
//     A -> BUSY, main<=in.
//   BUSY:  out_valid=1, in_ready=1.
//     A&I   -> BUSY, main<=in.
//     A&!I  -> FULL, skid<=in.
//     !A&I  -> EMPTY.
//     !A&!I -> hold.
//   FULL:  out_valid=1, in_ready=0.
//     I  -> BUSY, main<=skid.
//     !I -> hold.
//  Latency and throughput:
//  - Latency 1 cycle (accept at edge N, visible after edge N).
//  - Throughput 1 per cycle while out_ready=1.
//  - Order strictly preserved; no entry dropped or duplicated except by flush/rst.
//  flush (sync, beats all handshakes):
//  - Next state EMPTY; main/skid ctrl cleared to 0; data regs keep stale value.
//  - An accept or issue in the flush cycle is discarded; upstream must be flushed together with this stage.
//  - stall_cnt unaffected.
//  rst (overrides flush):
//  - state=EMPTY; main/skid data and ctrl cleared to 0; stall_cnt=0.
//  - Outputs after reset: out_valid=0, in_ready=1, data_out=0, ctrl_out=0, stall_cnt=0.
//  - rst mid-transfer discards both entries.
//  stall_cnt:
//  - +1 per cycle with out_valid & !out_ready (sampled pre-edge).
//  - Saturates at 2^CNT_W-1, no wrap; counts during FULL as well as BUSY.
//  - Cleared only by rst.
// TESTING
//  1 rst 2 cycles -> out_valid=0, in_ready=1, data_out=0, ctrl_out=0, stall_cnt=0.
//  2 out_ready=1; data_in 0x0001..0x0005 on consecutive cycles -> same values on data_out one cycle later.
//    in_ready stays 1; stall_cnt stays 0.
//  3 out_ready=0; send A=0x00AA, B=0x00BB, C=0x00CC back-to-back.
//    -> data_out=A; in_ready=0 after B accepted; C held upstream.
//    out_ready=1 -> A, B, C out in order; stall_cnt = number of stalled cycles.
//  4 FULL with A,B; assert flush 1 cycle -> next cycle out_valid=0, ctrl_out=0, in_ready=1.
//    A and B never issued.
//  5 flush & in_valid same cycle in EMPTY -> input dropped, out_valid stays 0.
//    rst & flush together -> reset values.
//  6 CNT_W=4; out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).
//    flush -> still 15; rst -> 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Pipeline stage register with valid/ready handshake, 2-entry
//               skid buffer, bubble-inserting flush and saturating stall count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] c_STATE_EMPTY = 2'd0;
    localparam logic [1:0] c_STATE_BUSY  = 2'd1;
    localparam logic [1:0] c_STATE_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic              r_outValid;
    logic              r_inReady;
    logic [DATA_W-1:0] r_mainData;
    logic [CTRL_W-1:0] r_mainCtrl;
    logic [DATA_W-1:0] r_skidData;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [CNT_W-1:0]  r_stallCnt;

    logic w_accept;
    logic w_issue;

    assign w_accept = in_valid & r_inReady;
    assign w_issue  = r_outValid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_STATE_EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_mainData <= '0;
            r_mainCtrl <= '0;
            r_skidData <= '0;
            r_skidCtrl <= '0;
        end else if (flush) begin
            // Bubble: control cleared so nothing downstream acts; data left stale.
            r_state    <= c_STATE_EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_mainCtrl <= '0;
            r_skidCtrl <= '0;
        end else begin
            case (r_state)
                c_STATE_EMPTY: begin
                    if (w_accept) begin
                        r_mainData <= data_in;
                        r_mainCtrl <= ctrl_in;
                        r_outValid <= 1'b1;
                        r_state    <= c_STATE_BUSY;
                    end
                end
                c_STATE_BUSY: begin
                    if (w_accept && w_issue) begin
                        r_mainData <= data_in;
                        r_mainCtrl <= ctrl_in;
                    end else if (w_accept) begin
                        r_skidData <= data_in;
                        r_skidCtrl <= ctrl_in;
                        r_inReady  <= 1'b0;
                        r_state    <= c_STATE_FULL;
                    end else if (w_issue) begin
                        // Keep ctrl_out zero while the stage is empty.
                        r_mainCtrl <= '0;
                        r_outValid <= 1'b0;
                        r_state    <= c_STATE_EMPTY;
                    end
                end
                c_STATE_FULL: begin
                    if (w_issue) begin
                        r_mainData <= r_skidData;
                        r_mainCtrl <= r_skidCtrl;
                        r_skidCtrl <= '0;
                        r_inReady  <= 1'b1;
                        r_state    <= c_STATE_BUSY;
                    end
                end
                default: begin
                    r_state    <= c_STATE_EMPTY;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_mainCtrl <= '0;
                    r_skidCtrl <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (r_outValid && !out_ready && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign data_out  = r_mainData;
    assign ctrl_out  = r_mainCtrl;
    assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed + randomized bench; expected outputs come from a
//               depth-2 FIFO reference model with a saturating stall count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DW      = 16;
    localparam int CW      = 12;
    localparam int NW      = 4;
    localparam int CNT_MAX = (1 << NW) - 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst, flush, inValid, outReady;
    logic          inReady, outValid;
    logic [DW-1:0] dataIn, dataOut;
    logic [CW-1:0] ctrlIn, ctrlOut;
    logic [NW-1:0] stallCnt;

    int checks = 0;
    int errors = 0;

    entry_t q[$];
    int     mCnt = 0;
    bit     mDataZero = 1'b0;
    bit     lastAccept = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady),
        .data_in(dataIn), .ctrl_in(ctrlIn),
        .out_valid(outValid), .out_ready(outReady),
        .data_out(dataOut), .ctrl_out(ctrlOut),
        .stall_cnt(stallCnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the FIFO model, compare after the edge.
    task automatic cycle(input logic r, input logic f, input logic v, input logic o,
                         input logic [DW-1:0] d, input logic [CW-1:0] c);
        bit     a, i;
        entry_t e;
        rst = r; flush = f; inValid = v; outReady = o; dataIn = d; ctrlIn = c;
        a = v && (q.size() < 2);
        i = (q.size() > 0) && o;
        if ((q.size() > 0) && !o && (mCnt < CNT_MAX)) mCnt++;
        @(posedge clk);
        lastAccept = 1'b0;
        if (r) begin
            q.delete(); mCnt = 0; mDataZero = 1'b1;
        end else if (f) begin
            q.delete();
        end else begin
            if (i) void'(q.pop_front());
            if (a) begin
                e.d = d; e.c = c;
                q.push_back(e);
                mDataZero = 1'b0;
                lastAccept = 1'b1;
            end
        end
        #1;
        check("out_valid", 32'(outValid), 32'(q.size() > 0));
        check("in_ready", 32'(inReady), 32'(q.size() < 2));
        check("ctrl_out", 32'(ctrlOut), (q.size() > 0) ? 32'(q[0].c) : 32'd0);
        if (q.size() > 0)  check("data_out", 32'(dataOut), 32'(q[0].d));
        else if (mDataZero) check("data_out_rst", 32'(dataOut), 32'd0);
        check("stall_cnt", 32'(stallCnt), 32'(mCnt));
    endtask

    initial begin
        bit            pending;
        logic [DW-1:0] pd;
        logic [CW-1:0] pc;
        bit            f, o;

        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        dataIn = '0; ctrlIn = '0;

        // Reset
        cycle(1, 0, 0, 0, '0, '0);
        cycle(1, 0, 0, 0, '0, '0);

        // Streaming at full rate
        for (int k = 1; k <= 5; k++) cycle(0, 0, 1, 1, DW'(k), CW'(k));
        cycle(0, 0, 0, 1, '0, '0);

        // Backpressure: A, B fill the stage, C waits upstream
        cycle(0, 0, 1, 0, 16'h00AA, 12'h0A1);
        cycle(0, 0, 1, 0, 16'h00BB, 12'h0B2);
        cycle(0, 0, 1, 0, 16'h00CC, 12'h0C3);
        cycle(0, 0, 1, 0, 16'h00CC, 12'h0C3);
        cycle(0, 0, 1, 1, 16'h00CC, 12'h0C3);
        cycle(0, 0, 1, 1, 16'h00CC, 12'h0C3);
        cycle(0, 0, 0, 1, '0, '0);
        cycle(0, 0, 0, 1, '0, '0);

        // Flush while FULL
        cycle(0, 0, 1, 0, 16'h1111, 12'h111);
        cycle(0, 0, 1, 0, 16'h2222, 12'h222);
        cycle(0, 1, 0, 1, '0, '0);
        cycle(0, 0, 0, 1, '0, '0);

        // Flush with input in EMPTY, then rst together with flush
        cycle(0, 1, 1, 1, 16'h5555, 12'h555);
        cycle(0, 0, 0, 1, '0, '0);
        cycle(0, 0, 1, 0, 16'h7777, 12'h777);
        cycle(1, 1, 1, 1, 16'h8888, 12'h888);

        // Stall counter saturation, flush-immune, cleared by rst
        cycle(0, 0, 1, 0, 16'h9999, 12'h999);
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, 0, '0, '0);
        check("stall_sat", 32'(stallCnt), 32'(CNT_MAX));
        cycle(0, 1, 0, 0, '0, '0);
        check("stall_after_flush", 32'(stallCnt), 32'(CNT_MAX));
        cycle(1, 0, 0, 0, '0, '0);
        check("stall_after_rst", 32'(stallCnt), 32'd0);

        // Randomized traffic with a well-behaved upstream
        pending = 1'b0; pd = '0; pc = '0;
        for (int k = 0; k < 400; k++) begin
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                pending = 1'b1;
                pd = DW'($urandom);
                pc = CW'($urandom);
            end
            o = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 39) == 0);
            cycle(0, f, pending, o, pd, pc);
            if (lastAccept || f) pending = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
